// File: rtl/data_mem_bridge_pkg.sv
// Shared definitions for the data-side memory bridge:
// access size codes, FSM states, byte strobe patterns and alignment helpers.
package data_mem_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_e;

    // Size code 11 behaves as a word everywhere.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return |lo;
        endcase
    endfunction

    function automatic logic [1:0] force_align(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// CPU-side and bus-side signals of the data memory bridge.
// slave is the bridge's view; master is the core/SRAM environment's view.
interface data_mem_bridge_if #(
    parameter int ADDR_W = 32
) ();

    logic              mem_req_i;
    logic              mem_wr_i;
    logic [1:0]        mem_size_i;
    logic              mem_sign_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_stall_o;
    logic              mem_valid_o;
    logic [31:0]       mem_rdata_o;
    logic              mem_adel_o;
    logic              mem_ades_o;
    logic              mem_buserr_o;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport slave (
        input  mem_req_i, mem_wr_i, mem_size_i, mem_sign_i,
        input  mem_addr_i, mem_wdata_i,
        output mem_stall_o, mem_valid_o, mem_rdata_o,
        output mem_adel_o, mem_ades_o, mem_buserr_o,
        output data_req, data_wr, data_size, data_addr,
        output data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport master (
        output mem_req_i, mem_wr_i, mem_size_i, mem_sign_i,
        output mem_addr_i, mem_wdata_i,
        input  mem_stall_o, mem_valid_o, mem_rdata_o,
        input  mem_adel_o, mem_ades_o, mem_buserr_o,
        input  data_req, data_wr, data_size, data_addr,
        input  data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/data_mem_bridge_align.sv
// Byte-lane logic: store strobes and lane replication, plus
// load-data extraction with sign/zero extension.
module data_mem_bridge_align
    import data_mem_bridge_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    // Select lanes and extension by access size; 11 falls through as word.
    always_comb begin
        wstrb     = STRB_WORD;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (size)
            SZ_BYTE: begin
                wstrb     = STRB_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wstrb     = STRB_HALF << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_bridge.sv
// MEM-stage to SRAM-like bus bridge: request latching, address/data
// handshake FSM, pipeline stall, alignment errors and bus timeout.
module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input logic                clk,
    input logic                rst,
    data_mem_bridge_if.slave   io
);

    localparam bit          TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYC - 1) : 32'h0;

    state_e state_q;
    state_e state_d;

    logic              misalign;
    logic              aligned;
    logic              accept;
    logic              complete;
    logic              timeout;
    logic              done;
    logic [1:0]        lo_eff;
    logic [ADDR_W-1:0] eff_addr;

    logic [1:0]        size_q;
    logic              sign_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       cnt_q;

    logic [3:0]        issue_wstrb;
    logic [31:0]       issue_wdata;
    logic [31:0]       load_data;
    logic [31:0]       load_fresh;

    logic [31:0]       unused_issue_rdata;
    logic [3:0]        unused_load_wstrb;
    logic [31:0]       unused_load_wdata;

    assign misalign = ALIGN_CHECK
                    ? is_misaligned(io.mem_size_i, io.mem_addr_i[1:0])
                    : 1'b0;
    assign aligned  = ~misalign;
    assign lo_eff   = ALIGN_CHECK
                    ? io.mem_addr_i[1:0]
                    : force_align(io.mem_size_i, io.mem_addr_i[1:0]);
    assign eff_addr = {io.mem_addr_i[ADDR_W-1:2], lo_eff};

    data_mem_bridge_align u_store_align (
        .size      (io.mem_size_i),
        .sign      (1'b0),
        .addr_lo   (lo_eff),
        .wdata     (io.mem_wdata_i),
        .rdata     (32'h0),
        .wstrb     (issue_wstrb),
        .wdata_rep (issue_wdata),
        .rdata_ext (unused_issue_rdata)
    );

    data_mem_bridge_align u_load_align (
        .size      (size_q),
        .sign      (sign_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (32'h0),
        .rdata     (io.data_rdata),
        .wstrb     (unused_load_wstrb),
        .wdata_rep (unused_load_wdata),
        .rdata_ext (load_data)
    );

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state plus accept/complete/timeout strobes.
    // A data_ok that lands together with addr_ok completes at once,
    // and completion beats a timeout expiring in the same cycle.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io.mem_req_i && aligned) begin
                    accept  = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (io.data_addr_ok) begin
                    complete = io.data_data_ok;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                complete = io.data_data_ok;
            end
            default: state_d = ST_IDLE;
        endcase
        if (TO_EN && state_q != ST_IDLE && cnt_q == TO_LAST && !complete)
            timeout = 1'b1;
        if (complete || timeout)
            state_d = ST_IDLE;
    end

    assign done       = complete | timeout;
    assign load_fresh = (complete && !wr_q) ? load_data : 32'h0;

    // Capture the request so the bus sees a stable transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            size_q  <= io.mem_size_i;
            sign_q  <= io.mem_sign_i;
            wr_q    <= io.mem_wr_i;
            addr_q  <= eff_addr;
            wstrb_q <= io.mem_wr_i ? issue_wstrb : 4'h0;
            wdata_q <= issue_wdata;
        end
    end

    // Cycles spent waiting on the bus since the request was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt_q <= 32'h0;
        else if (accept)            cnt_q <= 32'h0;
        else if (state_q != ST_IDLE) cnt_q <= cnt_q + 32'h1;
    end

    // Hold the last completed load result until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rdata_q <= 32'h0;
        else if (done) rdata_q <= load_fresh;
    end

    assign io.mem_stall_o  = io.mem_req_i & aligned & ~done;
    assign io.mem_valid_o  = done;
    assign io.mem_rdata_o  = done ? load_fresh : rdata_q;
    assign io.mem_adel_o   = io.mem_req_i & ~io.mem_wr_i & misalign;
    assign io.mem_ades_o   = io.mem_req_i &  io.mem_wr_i & misalign;
    assign io.mem_buserr_o = timeout;

    assign io.data_req   = (state_q == ST_ADDR);
    assign io.data_wr    = wr_q;
    assign io.data_size  = size_q;
    assign io.data_addr  = addr_q;
    assign io.data_wstrb = wstrb_q;
    assign io.data_wdata = wdata_q;

endmodule
